mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_pkg.sv | 76 +++++++
 rtl/mem_access_if.sv | 31 +++
 rtl/mem_access_load_align.sv | 24 ++
 rtl/mem_access.sv | 141 ++++++++++++++
 tb/tb_mem_access.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Core types shared by the memory-access stage: execute/writeback records and
// load/store funct3 decode helpers.
package corePckg;

   localparam int cXLEN = 32;

   typedef enum logic [2:0] {
      LS_B  = 3'b000,
      LS_H  = 3'b001,
      LS_W  = 3'b010,
      LS_BU = 3'b100,
      LS_HU = 3'b101
   } tLsFunct3;

   typedef struct packed {
      logic [cXLEN-1:0] addr;
      logic [cXLEN-1:0] data;
      logic [4:0]       rdAddr;
      logic [2:0]       opType;
      logic             read;
      logic             write;
   } tMemOp;

   typedef struct packed {
      logic             dv;
      logic [4:0]       addr;
      logic [cXLEN-1:0] data;
   } tRegOp;

   typedef struct packed {
      tMemOp memOp;
      tRegOp regOp;
   } tAluOut;

   function automatic logic isLegal(input logic read, input logic write, input logic [2:0] opType);
      logic legal;
      legal = 1'b0;
      if (read && !write)
         legal = opType inside {LS_B, LS_H, LS_W, LS_BU, LS_HU};
      else if (write && !read)
         legal = opType inside {LS_B, LS_H, LS_W};
      return legal;
   endfunction

   // opType[1:0] encodes the access size for every legal load/store.
   function automatic logic isAligned(input logic [2:0] opType, input logic [1:0] addrLo);
      logic ok;
      case (opType[1:0])
         2'b01:   ok = !addrLo[0];
         2'b10:   ok = (addrLo == 2'b00);
         default: ok = 1'b1;
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] byteEnables(input logic [2:0] opType, input logic [1:0] addrLo);
      logic [3:0] be;
      case (opType[1:0])
         2'b00:   be = 4'b0001 << addrLo;
         2'b01:   be = 4'b0011 << addrLo;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [cXLEN-1:0] storeData(input logic [2:0] opType, input logic [cXLEN-1:0] data);
      logic [cXLEN-1:0] wd;
      case (opType[1:0])
         2'b00:   wd = {4{data[7:0]}};
         2'b01:   wd = {2{data[15:0]}};
         default: wd = data;
      endcase
      return wd;
   endfunction

endpackage

// File: rtl/mem_access_if.sv
// Execute-side, writeback and memory-bus signals of the memory-access stage.
interface mem_access_if;
   import corePckg::*;

   tAluOut           iAluOut;
   logic             oStall;
   tRegOp            oRegWr;
   logic             oMemReq;
   logic             oMemWe;
   logic [cXLEN-1:0] oMemAddr;
   logic [3:0]       oMemBe;
   logic [cXLEN-1:0] oMemWData;
   logic             iMemAck;
   logic [cXLEN-1:0] iMemRData;
   logic             oMisalign;
   logic             oIllegal;
   logic             oBusErr;

   modport master (
      input  iAluOut, iMemAck, iMemRData,
      output oStall, oRegWr, oMemReq, oMemWe, oMemAddr, oMemBe, oMemWData,
             oMisalign, oIllegal, oBusErr
   );

   modport slave (
      output iAluOut, iMemAck, iMemRData,
      input  oStall, oRegWr, oMemReq, oMemWe, oMemAddr, oMemBe, oMemWData,
             oMisalign, oIllegal, oBusErr
   );

endinterface

// File: rtl/mem_access_load_align.sv
// Picks the addressed byte/half lane out of a read word and sign/zero extends it.
module mem_load_align
   import corePckg::*;
(
   input  logic [cXLEN-1:0] iRData,
   input  logic [1:0]       iAddrLo,
   input  logic [2:0]       iOpType,
   output logic [cXLEN-1:0] oData
);

   logic [cXLEN-1:0] shifted;

   always_comb begin
      shifted = iRData >> {iAddrLo, 3'b000};
      case (iOpType)
         LS_B:    oData = {{(cXLEN-8){shifted[7]}}, shifted[7:0]};
         LS_H:    oData = {{(cXLEN-16){shifted[15]}}, shifted[15:0]};
         LS_BU:   oData = {{(cXLEN-8){1'b0}}, shifted[7:0]};
         LS_HU:   oData = {{(cXLEN-16){1'b0}}, shifted[15:0]};
         default: oData = iRData;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: decodes one load/store per idle cycle, runs a single bus
// transaction with a bounded wait, and forwards register results to writeback.
module mem_access
   import corePckg::*;
#(
   parameter int pMaxWait = 15
) (
   input  logic         iClk,
   input  logic         iRst,
   mem_access_if.master bus
);

   typedef enum logic {IDLE, REQ} tState;

   localparam logic [7:0] cWaitLast = 8'(pMaxWait - 1);

   tState            state_q, state_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d;
   logic             mem_we_q, mem_we_d;
   logic [3:0]       mem_be_q, mem_be_d;
   logic [cXLEN-1:0] mem_addr_q, mem_addr_d;
   logic [cXLEN-1:0] mem_wdata_q, mem_wdata_d;
   logic [4:0]       rd_addr_q, rd_addr_d;
   logic [2:0]       op_type_q, op_type_d;
   logic [1:0]       addr_lo_q, addr_lo_d;
   tRegOp            reg_wr_q, reg_wr_d;
   logic             misalign_q, misalign_d;
   logic             illegal_q, illegal_d;
   logic             bus_err_q, bus_err_d;
   logic [cXLEN-1:0] load_data;
   tMemOp            mem_op;

   assign mem_op = bus.iAluOut.memOp;

   mem_load_align u_load_align (
      .iRData  (bus.iMemRData),
      .iAddrLo (addr_lo_q),
      .iOpType (op_type_q),
      .oData   (load_data)
   );

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      mem_we_d    = mem_we_q;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rd_addr_d   = rd_addr_q;
      op_type_d   = op_type_q;
      addr_lo_d   = addr_lo_q;
      reg_wr_d    = '0;
      misalign_d  = 1'b0;
      illegal_d   = 1'b0;
      bus_err_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (mem_op.read || mem_op.write) begin
               // Legality is judged first: an illegal opType has no defined size to align against.
               if (!isLegal(mem_op.read, mem_op.write, mem_op.opType)) begin
                  illegal_d = 1'b1;
               end else if (!isAligned(mem_op.opType, mem_op.addr[1:0])) begin
                  misalign_d = 1'b1;
               end else begin
                  state_d     = REQ;
                  wait_cnt_d  = '0;
                  mem_we_d    = mem_op.write;
                  mem_addr_d  = {mem_op.addr[cXLEN-1:2], 2'b00};
                  mem_be_d    = byteEnables(mem_op.opType, mem_op.addr[1:0]);
                  mem_wdata_d = storeData(mem_op.opType, mem_op.data);
                  rd_addr_d   = mem_op.rdAddr;
                  op_type_d   = mem_op.opType;
                  addr_lo_d   = mem_op.addr[1:0];
               end
            end else if (bus.iAluOut.regOp.dv) begin
               reg_wr_d = bus.iAluOut.regOp;
            end
         end
         REQ: begin
            if (bus.iMemAck) begin
               state_d = IDLE;
               if (!mem_we_q && rd_addr_q != 5'd0) begin
                  reg_wr_d.dv   = 1'b1;
                  reg_wr_d.addr = rd_addr_q;
                  reg_wr_d.data = load_data;
               end
            end else if (wait_cnt_q == cWaitLast) begin
               state_d   = IDLE;
               bus_err_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
      endcase
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q     <= IDLE;
         wait_cnt_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rd_addr_q   <= '0;
         op_type_q   <= '0;
         addr_lo_q   <= '0;
         reg_wr_q    <= '0;
         misalign_q  <= 1'b0;
         illegal_q   <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rd_addr_q   <= rd_addr_d;
         op_type_q   <= op_type_d;
         addr_lo_q   <= addr_lo_d;
         reg_wr_q    <= reg_wr_d;
         misalign_q  <= misalign_d;
         illegal_q   <= illegal_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign bus.oStall    = (state_q == REQ);
   assign bus.oMemReq   = (state_q == REQ);
   assign bus.oMemWe    = mem_we_q;
   assign bus.oMemBe    = mem_be_q;
   assign bus.oMemAddr  = mem_addr_q;
   assign bus.oMemWData = mem_wdata_q;
   assign bus.oRegWr    = reg_wr_q;
   assign bus.oMisalign = misalign_q;
   assign bus.oIllegal  = illegal_q;
   assign bus.oBusErr   = bus_err_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: fixed vector table, hand-written reset/ack corner cases,
// and random operations checked against a transaction-level model.
module tb_mem_access;
   import corePckg::*;

   localparam int MAXW = 15;
   localparam int K_NONE = 0, K_REG = 1, K_ILL = 2, K_MIS = 3, K_BUS = 4, K_TMO = 5;

   typedef struct {
      tAluOut      alu;
      int          ack_lat;   // REQ cycle (1-based) that carries the ack, 0 = never
      logic [31:0] rdata;
      int          kind;
      logic [31:0] e_addr;
      logic        e_we;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
      logic        e_dv;
      logic [4:0]  e_rd;
      logic [31:0] e_data;
   } tVec;

   logic iClk = 1'b0;
   logic iRst;
   int   checks = 0;
   int   errors = 0;

   mem_access_if bus();

   mem_access #(.pMaxWait(MAXW)) dut (
      .iClk (iClk),
      .iRst (iRst),
      .bus  (bus.master)
   );

   always #5 iClk = ~iClk;

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   function automatic tAluOut mk_mem(input logic r, input logic w, input logic [2:0] op,
                                     input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd);
      tAluOut a;
      a = '0;
      a.memOp.read = r;
      a.memOp.write = w;
      a.memOp.opType = op;
      a.memOp.addr = addr;
      a.memOp.data = data;
      a.memOp.rdAddr = rd;
      return a;
   endfunction

   function automatic tAluOut mk_reg(input logic [4:0] rd, input logic [31:0] data);
      tAluOut a;
      a = '0;
      a.regOp.dv = 1'b1;
      a.regOp.addr = rd;
      a.regOp.data = data;
      return a;
   endfunction

   function automatic tVec mkv(input tAluOut a, input int lat, input logic [31:0] rdata, input int kind,
                               input logic [31:0] e_addr, input logic e_we, input logic [3:0] e_be,
                               input logic [31:0] e_wdata, input logic e_dv, input logic [4:0] e_rd,
                               input logic [31:0] e_data);
      tVec v;
      v.alu = a; v.ack_lat = lat; v.rdata = rdata; v.kind = kind;
      v.e_addr = e_addr; v.e_we = e_we; v.e_be = e_be; v.e_wdata = e_wdata;
      v.e_dv = e_dv; v.e_rd = e_rd; v.e_data = e_data;
      return v;
   endfunction

   // Reference: outcome of one issued operation, worked out from sizes and byte offsets.
   function automatic tVec model(input tAluOut a, input int lat, input logic [31:0] rdata);
      tVec m;
      tMemOp mo;
      int size, off;
      logic [63:0] val, mask;
      m = mkv(a, lat, rdata, K_NONE, 0, 0, 0, 0, 0, 0, 0);
      mo = a.memOp;
      if (!mo.read && !mo.write) begin
         if (a.regOp.dv) begin
            m.kind = K_REG; m.e_dv = 1'b1; m.e_rd = a.regOp.addr; m.e_data = a.regOp.data;
         end
         return m;
      end
      if ((mo.read && mo.write) ||
          (mo.read && !(mo.opType inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ||
          (mo.write && !(mo.opType inside {3'd0, 3'd1, 3'd2}))) begin
         m.kind = K_ILL;
         return m;
      end
      case (mo.opType)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         default:    size = 4;
      endcase
      off = int'(mo.addr % 32'd4);
      if (off % size != 0) begin
         m.kind = K_MIS;
         return m;
      end
      m.e_addr = mo.addr - 32'(off);
      m.e_we = mo.write;
      m.e_be = 4'(((1 << size) - 1) << off);
      for (int lane = 0; lane < 4; lane++)
         m.e_wdata[8*lane +: 8] = mo.data[8*(lane % size) +: 8];
      if (lat < 1 || lat > MAXW) begin
         m.kind = K_TMO;
         return m;
      end
      m.kind = K_BUS;
      if (mo.read && mo.rdAddr != 5'd0) begin
         mask = (64'd1 << (8*size)) - 64'd1;
         val = ({32'd0, rdata} >> (8*off)) & mask;
         if ((mo.opType == 3'd0 || mo.opType == 3'd1) && val[8*size-1])
            val = val | ~mask;
         m.e_dv = 1'b1; m.e_rd = mo.rdAddr; m.e_data = val[31:0];
      end
      return m;
   endfunction

   // Issues one op from IDLE, plays the bus slave, and checks every visible effect.
   task automatic run_txn(input tVec v, input int idx);
      int n;
      $display("txn %0d kind %0d rd %0b wr %0b op %b addr %h lat %0d", idx, v.kind,
               v.alu.memOp.read, v.alu.memOp.write, v.alu.memOp.opType, v.alu.memOp.addr, v.ack_lat);
      bus.iAluOut = v.alu;
      bus.iMemAck = 1'b0;
      tick();
      bus.iAluOut = '0;
      case (v.kind)
         K_NONE, K_REG: begin
            check($sformatf("t%0d regwr_dv", idx), 32'(bus.oRegWr.dv), 32'(v.e_dv));
            if (v.e_dv) begin
               check($sformatf("t%0d regwr_addr", idx), 32'(bus.oRegWr.addr), 32'(v.e_rd));
               check($sformatf("t%0d regwr_data", idx), bus.oRegWr.data, v.e_data);
            end
            check($sformatf("t%0d no_req", idx), 32'(bus.oMemReq), 32'd0);
         end
         K_ILL, K_MIS: begin
            check($sformatf("t%0d illegal", idx), 32'(bus.oIllegal), 32'(v.kind == K_ILL));
            check($sformatf("t%0d misalign", idx), 32'(bus.oMisalign), 32'(v.kind == K_MIS));
            check($sformatf("t%0d no_req", idx), 32'({bus.oMemReq, bus.oStall, bus.oRegWr.dv}), 32'd0);
         end
         default: begin
            check($sformatf("t%0d we", idx), 32'(bus.oMemWe), 32'(v.e_we));
            if (v.e_we)
               check($sformatf("t%0d wdata", idx), bus.oMemWData, v.e_wdata);
            n = 0;
            while (bus.oStall && n < MAXW + 2) begin
               n++;
               check($sformatf("t%0d c%0d req", idx, n), 32'(bus.oMemReq), 32'd1);
               check($sformatf("t%0d c%0d addr", idx, n), bus.oMemAddr, v.e_addr);
               check($sformatf("t%0d c%0d be", idx, n), 32'(bus.oMemBe), 32'(v.e_be));
               bus.iMemAck = (n == v.ack_lat);
               bus.iMemRData = (n == v.ack_lat) ? v.rdata : $urandom;
               tick();
            end
            bus.iMemAck = 1'b0;
            check($sformatf("t%0d stall_cycles", idx), 32'(n), 32'((v.kind == K_BUS) ? v.ack_lat : MAXW));
            check($sformatf("t%0d bus_err", idx), 32'(bus.oBusErr), 32'(v.kind == K_TMO));
            check($sformatf("t%0d req_drop", idx), 32'(bus.oMemReq), 32'd0);
            check($sformatf("t%0d regwr_dv", idx), 32'(bus.oRegWr.dv), 32'(v.e_dv));
            if (v.e_dv) begin
               check($sformatf("t%0d regwr_addr", idx), 32'(bus.oRegWr.addr), 32'(v.e_rd));
               check($sformatf("t%0d regwr_data", idx), bus.oRegWr.data, v.e_data);
            end
         end
      endcase
      tick();
      check($sformatf("t%0d quiet", idx),
            32'({bus.oIllegal, bus.oMisalign, bus.oBusErr, bus.oRegWr.dv, bus.oMemReq}), 32'd0);
   endtask

   tVec         vec [17];
   tVec         rv;
   tAluOut      ra;
   logic [2:0]  load_ops [5];
   logic [2:0]  rop;
   logic [31:0] raddr;
   logic        rr;
   int          sel, rlat;

   initial begin
      vec[0]  = mkv(mk_mem(1,0,3'b010,32'h100,0,5'd3), 3, 32'hDEADBEEF, K_BUS, 32'h100, 0, 4'b1111, 0, 1, 5'd3, 32'hDEADBEEF);
      vec[1]  = mkv(mk_mem(1,0,3'b000,32'h203,0,5'd4), 1, 32'h80112233, K_BUS, 32'h200, 0, 4'b1000, 0, 1, 5'd4, 32'hFFFFFF80);
      vec[2]  = mkv(mk_mem(1,0,3'b100,32'h203,0,5'd4), 2, 32'h80112233, K_BUS, 32'h200, 0, 4'b1000, 0, 1, 5'd4, 32'h00000080);
      vec[3]  = mkv(mk_mem(0,1,3'b001,32'h302,32'h0000ABCD,5'd0), 2, 0, K_BUS, 32'h300, 1, 4'b1100, 32'hABCDABCD, 0, 0, 0);
      vec[4]  = mkv(mk_mem(1,0,3'b010,32'h101,0,5'd1), 1, 0, K_MIS, 0, 0, 0, 0, 0, 0, 0);
      vec[5]  = mkv(mk_mem(1,0,3'b011,32'h100,0,5'd1), 1, 0, K_ILL, 0, 0, 0, 0, 0, 0, 0);
      vec[6]  = mkv(mk_mem(1,1,3'b010,32'h100,0,5'd1), 1, 0, K_ILL, 0, 0, 0, 0, 0, 0, 0);
      vec[7]  = mkv(mk_mem(0,1,3'b100,32'h100,0,5'd0), 1, 0, K_ILL, 0, 0, 0, 0, 0, 0, 0);
      vec[8]  = mkv(mk_mem(1,0,3'b001,32'h106,0,5'd9), 4, 32'h80017FFF, K_BUS, 32'h104, 0, 4'b1100, 0, 1, 5'd9, 32'hFFFF8001);
      vec[9]  = mkv(mk_mem(1,0,3'b101,32'h102,0,5'd10), 1, 32'hF00D1234, K_BUS, 32'h100, 0, 4'b1100, 0, 1, 5'd10, 32'h0000F00D);
      vec[10] = mkv(mk_mem(0,1,3'b000,32'h001,32'h12345678,5'd0), 1, 0, K_BUS, 32'h000, 1, 4'b0010, 32'h78787878, 0, 0, 0);
      vec[11] = mkv(mk_mem(0,1,3'b010,32'h404,32'hCAFEF00D,5'd0), MAXW, 0, K_BUS, 32'h404, 1, 4'b1111, 32'hCAFEF00D, 0, 0, 0);
      vec[12] = mkv(mk_mem(1,0,3'b010,32'h008,0,5'd0), 1, 32'h1, K_BUS, 32'h008, 0, 4'b1111, 0, 0, 0, 0);
      vec[13] = mkv(mk_mem(1,0,3'b010,32'h040,0,5'd6), 0, 0, K_TMO, 32'h040, 0, 4'b1111, 0, 0, 0, 0);
      vec[14] = mkv(mk_reg(5'd5, 32'd7), 0, 0, K_REG, 0, 0, 0, 0, 1, 5'd5, 32'd7);
      vec[15] = mkv(mk_mem(1,0,3'b001,32'h003,0,5'd2), 1, 0, K_MIS, 0, 0, 0, 0, 0, 0, 0);
      vec[16] = mkv(mk_mem(1,0,3'b000,32'h7FF,0,5'd31), 2, 32'h7F000000, K_BUS, 32'h7FC, 0, 4'b1000, 0, 1, 5'd31, 32'h0000007F);
      load_ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

      iRst = 1'b1;
      bus.iAluOut = '0;
      bus.iMemAck = 1'b0;
      bus.iMemRData = '0;
      tick();
      tick();
      check("rst req_stall_we", 32'({bus.oMemReq, bus.oStall, bus.oMemWe}), 32'd0);
      check("rst be", 32'(bus.oMemBe), 32'd0);
      check("rst addr", bus.oMemAddr, 32'd0);
      check("rst wdata", bus.oMemWData, 32'd0);
      check("rst regwr", 32'({bus.oRegWr.dv, bus.oRegWr.addr}), 32'd0);
      check("rst pulses", 32'({bus.oMisalign, bus.oIllegal, bus.oBusErr}), 32'd0);
      iRst = 1'b0;
      tick();

      for (int i = 0; i < 17; i++)
         run_txn(vec[i], i);

      // Ack while idle must be ignored.
      bus.iMemAck = 1'b1;
      bus.iMemRData = 32'h55AA55AA;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("idle_ack quiet", 32'({bus.oMemReq, bus.oStall, bus.oRegWr.dv, bus.oBusErr}), 32'd0);
      end
      bus.iMemAck = 1'b0;

      // Reset two cycles into a load: bus request drops at once, nothing follows.
      $display("txn reset_mid_req");
      bus.iAluOut = mk_mem(1, 0, 3'b010, 32'h200, 0, 5'd7);
      tick();
      bus.iAluOut = '0;
      tick();
      check("midrst in_req", 32'(bus.oMemReq), 32'd1);
      #2;
      iRst = 1'b1;
      #1;
      check("midrst req_drop", 32'({bus.oMemReq, bus.oStall}), 32'd0);
      tick();
      iRst = 1'b0;
      bus.iMemAck = 1'b1;
      bus.iMemRData = 32'h11111111;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("midrst quiet", 32'({bus.oMemReq, bus.oRegWr.dv, bus.oBusErr, bus.oIllegal, bus.oMisalign}), 32'd0);
      end
      bus.iMemAck = 1'b0;
      run_txn(mkv(mk_mem(1,0,3'b010,32'h200,0,5'd7), 2, 32'h13572468, K_BUS, 32'h200, 0, 4'b1111, 0, 1, 5'd7, 32'h13572468), 50);

      for (int i = 0; i < 150; i++) begin
         sel = int'($urandom_range(0, 19));
         if (sel < 3) begin
            ra = mk_reg(5'($urandom), $urandom);
         end else if (sel == 3) begin
            ra = '0;
            ra.regOp.data = $urandom;
         end else begin
            rr = 1'($urandom_range(0, 1));
            raddr = $urandom;
            if (sel < 17)
               rop = rr ? load_ops[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
            else
               rop = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0) begin
               if (rop == 3'd2) raddr[1:0] = 2'b00;
               else if (rop == 3'd1 || rop == 3'd5) raddr[0] = 1'b0;
            end
            ra = mk_mem(rr || sel == 4, !rr || sel == 4, rop, raddr, $urandom,
                        ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom));
         end
         if ($urandom_range(0, 9) == 0)
            rlat = 0;
         else if ($urandom_range(0, 4) == 0)
            rlat = int'($urandom_range(1, MAXW));
         else
            rlat = int'($urandom_range(1, 4));
         rv = model(ra, rlat, $urandom);
         run_txn(rv, 100 + i);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
